wom_streamer: RTL
=================

WOM_STREAMER -- requirements
Module: wom_streamer

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO capacity in 4-lane result entries (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 32, meaning width of the write-output-memory address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_wom  input  1  write strobe from the EXE/MEM pipe register; one 4-lane result per asserted cycle.
REQ-006 wom_addr  input  ADDR_W  base address of the 4-lane result.
REQ-007 r1, r2, r3, r4  input  32 each  lane results, r1 = lane 0.
REQ-008 pix_valid  output  1  pix_data/pix_addr hold a valid pixel.
REQ-009 pix_ready  input  1  consumer accepts the pixel when pix_valid and pix_ready are both high.
REQ-010 pix_data  output  8  pixel value.
REQ-011 pix_addr  output  ADDR_W  pixel address = entry base + lane index.
REQ-012 busy  output  1  FIFO non-empty or a pixel pending.
REQ-013 overflow  output  1  sticky; a write was dropped.
REQ-014 drop_cnt  output  8  number of dropped writes, saturating at 255.

Function
REQ-015 Push occurs when wr_wom is high and (FIFO not full, or a pop occurs in the same cycle).
REQ-016 Write with FIFO full and no same-cycle pop is dropped; overflow set; drop_cnt incremented unless it is 255.
REQ-017 FSM states: IDLE (FIFO empty, pix_valid low) and SEND (lane index 0..3 driven from the FIFO head entry).
REQ-018 IDLE -> SEND on the cycle after the first push; pix_valid is high one cycle after wr_wom (latency 1).
REQ-019 In SEND, lane index advances by 1 on each handshake; pix_data/pix_addr hold stable while pix_valid is high and pix_ready is low.
REQ-020 Handshake on lane 3 pops the head entry and resets the lane index to 0; SEND is kept with no idle cycle if the FIFO still holds an entry, otherwise the FSM goes to IDLE.
REQ-021 pix_addr = head base + lane index, modulo 2^ADDR_W; 0xFFFFFFFF + 1 wraps to 0x00000000.
REQ-022 Pixel conversion: lane value bits [7:0] (truncation) unless REQ-027 applies.
REQ-023 Simultaneous push and pop when full: both take effect; occupancy unchanged; no drop.
REQ-024 FIFO read and write pointers wrap modulo DEPTH; full is detected with an extra pointer bit.
REQ-025 busy = pix_valid OR (occupancy != 0).

Reset
REQ-026 While rst is high at a clock edge: pointers and occupancy go to 0, the FSM goes to IDLE, lane index goes to 0, and pix_valid, busy, overflow and drop_cnt are all 0. pix_data and pix_addr are 0. Reset asserted mid-burst discards all buffered entries, and no further pixel is presented until a new push.

Configuration
REQ-027 When the macro WOM_SAT_EN is defined, pixel conversion treats the lane as signed 32-bit and clamps it: negative -> 0x00, >255 -> 0xFF, otherwise bits [7:0]. When the macro is not defined, truncation per REQ-022 applies.

Structure
REQ-028 Shared package vector_pkg holds the LANES=4 constant, a lane_vec_t typedef (4 x 32-bit lanes) and a wom_entry_t struct (base address + lane_vec_t).
REQ-029 FIFO storage and pointer logic live in one sub-module wom_fifo (push/pop/full/empty/count). The FSM, lane mux and conversion stay in wom_streamer.

Verification
REQ-030 Single write: wom_addr=0x100, r1..r4=1,2,3,4, pix_ready held high -> pixels (0x100,1),(0x101,2),(0x102,3),(0x103,4) on four consecutive cycles starting one cycle after wr_wom; busy drops after lane 3.
REQ-031 Backpressure: pix_ready low for 3 cycles during lane 1 -> pix_data/pix_addr stable for those 3 cycles; no lane skipped or repeated.
REQ-032 Overflow: DEPTH=4, pix_ready low, 6 writes -> 4 are accepted, overflow=1, drop_cnt=2; pix_ready then high -> exactly 16 pixels in write order.
REQ-033 Full with same-cycle pop: FIFO full, lane-3 handshake coincides with wr_wom -> write accepted, drop_cnt unchanged.
REQ-034 Conversion: lanes 0xFFFFFFFF, 0x00000123, 0x7F, 0 -> with WOM_SAT_EN: 0x00,0xFF,0x7F,0x00; without it: 0xFF,0x23,0x7F,0x00.
REQ-035 Reset mid-burst: rst during lane 2 with 2 entries queued -> next cycle pix_valid=0, busy=0, overflow=0; a following write at 0xFFFFFFFE streams addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/vector_pkg.sv
// vector_pkg: shared types for the write-output-memory (WOM) pixel path.
//   LANES        lanes per result entry
//   lane_vec_t   4 x 32-bit lane results, index 0 = lane 0 (r1)
//   wom_entry_t  base address + lane results for one write
//   wom_state_t  streamer FSM state
//   pix_conv     lane value -> 8-bit pixel. Defining WOM_SAT_EN selects the
//                signed clamp; otherwise the low byte is taken as-is.
package vector_pkg;
  localparam int LANES      = 4;
  localparam int WOM_ADDR_W = 32;

  typedef logic [LANES-1:0][31:0] lane_vec_t;

  typedef struct packed {
    logic [WOM_ADDR_W-1:0] base;
    lane_vec_t             lanes;
  } wom_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } wom_state_t;

  function automatic logic [7:0] pix_conv(input logic [31:0] v);
`ifdef WOM_SAT_EN
    // Sign bit set -> below zero; any of bits 30..8 set -> above 255.
    if (v[31])           return 8'h00;
    else if (|v[30:8])   return 8'hFF;
    else                 return v[7:0];
`else
    return v[7:0];
`endif
  endfunction
endpackage

// File: rtl/wom_fifo.sv
// wom_fifo: DEPTH-entry FIFO of 4-lane WOM results.
//   clk, rst        clock, synchronous active-high reset (pointers only)
//   i_push, i_pop   qualified push/pop; caller never pops empty or pushes
//                   full without a same-cycle pop
//   i_base/i_lanes  entry written on push
//   o_head_*        entry at the read pointer (combinational read)
//   o_full/o_empty  occupancy flags
//   o_count         occupancy 0..DEPTH
module wom_fifo
  import vector_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [ADDR_W-1:0]        i_base,
  input  lane_vec_t                i_lanes,
  output logic [ADDR_W-1:0]        o_head_base,
  output lane_vec_t                o_head_lanes,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_base_mem [DEPTH];
  lane_vec_t         r_lane_mem [DEPTH];
  // Extra MSB on each pointer tells full from empty when the indices match.
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_base_mem[r_wr_ptr[AW-1:0]] <= i_base;
      r_lane_mem[r_wr_ptr[AW-1:0]] <= i_lanes;
    end
  end

  assign o_head_base  = r_base_mem[r_rd_ptr[AW-1:0]];
  assign o_head_lanes = r_lane_mem[r_rd_ptr[AW-1:0]];
  assign o_empty      = (r_wr_ptr == r_rd_ptr);
  assign o_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count      = r_wr_ptr - r_rd_ptr;
endmodule

// File: rtl/wom_streamer.sv
// wom_streamer: buffers 4-lane results written by the EXE/MEM stage and
// streams them out one 8-bit pixel per handshake.
//   clk, rst            clock, synchronous active-high reset
//   wr_wom              write strobe, one 4-lane result per cycle
//   wom_addr            base address of the result
//   r1..r4              lane results (r1 = lane 0)
//   pix_valid/ready     output handshake
//   pix_data/pix_addr   pixel value and address (base + lane), 0 when idle
//   busy                pixel pending or FIFO non-empty
//   overflow, drop_cnt  sticky drop flag, saturating dropped-write count
// Build option: define WOM_SAT_EN for signed clamping pixel conversion.
module wom_streamer
  import vector_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_wom,
  input  logic [ADDR_W-1:0] wom_addr,
  input  logic [31:0]       r1,
  input  logic [31:0]       r2,
  input  logic [31:0]       r3,
  input  logic [31:0]       r4,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  wom_state_t        r_state;
  logic [1:0]        r_lane;
  logic              r_pix_valid;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_hs;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [ADDR_W-1:0] w_head_base;
  lane_vec_t         w_head_lanes;
  lane_vec_t         w_lanes_in;

  assign w_lanes_in = {r4, r3, r2, r1};
  assign w_hs       = r_pix_valid && pix_ready;
  assign w_pop      = w_hs && (r_lane == 2'd3);
  // A pop frees the slot the same cycle, so a full FIFO still accepts.
  assign w_push     = wr_wom && (!w_full || w_pop);
  assign w_drop     = wr_wom && w_full && !w_pop;

  wom_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_base       (wom_addr),
    .i_lanes      (w_lanes_in),
    .o_head_base  (w_head_base),
    .o_head_lanes (w_head_lanes),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lane      <= 2'd0;
      r_pix_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state     <= ST_SEND;
            r_pix_valid <= 1'b1;
            r_lane      <= 2'd0;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            if (r_lane == 2'd3) begin
              r_lane <= 2'd0;
              // Stay in SEND if another entry remains after this pop,
              // including one arriving in this same cycle.
              if (!(w_count > CW'(1)) && !w_push) begin
                r_state     <= ST_IDLE;
                r_pix_valid <= 1'b0;
              end
            end else begin
              r_lane <= r_lane + 2'd1;
            end
          end
        end
      endcase
    end
  end

  // Head entry and lane index only change on a handshake, so the muxed
  // pixel holds steady under backpressure.
  assign pix_valid = r_pix_valid;
  assign pix_data  = r_pix_valid ? pix_conv(w_head_lanes[r_lane]) : 8'h00;
  assign pix_addr  = r_pix_valid ? (w_head_base + ADDR_W'(r_lane)) : '0;
  assign busy      = r_pix_valid || !w_empty;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
endmodule
